wb_write_arbiter: RTL and testbench

- Shares the single register-file write port between two write-back requesters: the ALU result path and the data-memory load path.
- Each requester gets a one-entry holding register with a valid/ready handshake.
- A round-robin grant sequences the port, with an age override that preserves write-after-write order to the same register.
- Sits between the datapath result muxes and the register file; rf_* outputs are registered.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_hold_entry.sv | 62 ++++++
 rtl/wb_write_arbiter.sv | 165 ++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
package wb_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int ZERO_REG   = 0;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_LD  = 1'b1
  } rr_state_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_hold_entry.sv
// One-entry holding register for a write-back requester. It accepts on
// valid && ready and frees (or reloads) itself when granted.
module wb_hold_entry
  import wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              grant,
  output logic              ready,
  output logic              accept,
  output logic              hold_valid,
  output logic [ADDR_W-1:0] hold_addr,
  output logic [DATA_W-1:0] hold_data
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Ready is a function of entry state and grant only, never of in_valid.
  assign ready  = !reset && (!valid_q || grant);
  assign accept = in_valid && ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (accept) begin
      valid_d = 1'b1;
      addr_d  = in_addr;
      data_d  = in_data;
    end else if (grant) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here keep every flop sampling pre-edge values.
    if (reset) begin
      // NOTE: addr/data are cleared too so a reset leaves no stale pending write visible.
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign hold_valid = valid_q;
  assign hold_addr  = addr_q;
  assign hold_data  = data_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Two-requester (ALU / load) arbiter for the single register-file write port.
// Optional feature macro: WB_BYPASS_EN adds a combinational forwarding lookup.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_busy
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] fwd_raddr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  logic              alu_hold_v, ld_hold_v;
  logic [ADDR_W-1:0] alu_hold_addr, ld_hold_addr;
  logic [DATA_W-1:0] alu_hold_data, ld_hold_data;
  logic              alu_grant, ld_grant;
  logic              alu_accept, ld_accept;

  rr_state_t         rr_q, rr_d;
  logic              ld_older_q, ld_older_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  wb_hold_entry #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_entry (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (alu_valid),
    .in_addr   (alu_addr),
    .in_data   (alu_data),
    .grant     (alu_grant),
    .ready     (alu_ready),
    .accept    (alu_accept),
    .hold_valid(alu_hold_v),
    .hold_addr (alu_hold_addr),
    .hold_data (alu_hold_data)
  );

  wb_hold_entry #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ld_entry (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (ld_valid),
    .in_addr   (ld_addr),
    .in_data   (ld_data),
    .grant     (ld_grant),
    .ready     (ld_ready),
    .accept    (ld_accept),
    .hold_valid(ld_hold_v),
    .hold_addr (ld_hold_addr),
    .hold_data (ld_hold_data)
  );

  // Same-address contention goes to the older entry to keep WAW order;
  // otherwise the round-robin pointer decides and then flips.
  always_comb begin
    alu_grant = 1'b0;
    ld_grant  = 1'b0;
    rr_d      = rr_q;
    if (alu_hold_v && ld_hold_v) begin
      if (alu_hold_addr == ld_hold_addr) begin
        ld_grant  = ld_older_q;
        alu_grant = !ld_older_q;
      end else if (rr_q == PRI_LD) begin
        ld_grant = 1'b1;
        rr_d     = PRI_ALU;
      end else begin
        alu_grant = 1'b1;
        rr_d      = PRI_LD;
      end
    end else begin
      alu_grant = alu_hold_v;
      ld_grant  = ld_hold_v;
    end
  end

  // A fresh ALU capture is never older than a surviving load; a load-only
  // capture is younger than any surviving ALU entry.
  always_comb begin
    ld_older_d = ld_older_q;
    if (alu_accept)     ld_older_d = 1'b1;
    else if (ld_accept) ld_older_d = 1'b0;
  end

  always_comb begin
    sel_addr   = ld_grant ? ld_hold_addr : alu_hold_addr;
    sel_data   = ld_grant ? ld_hold_data : alu_hold_data;
    rf_we_d    = (alu_grant || ld_grant) && (sel_addr != ADDR_W'(ZERO_REG));
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (rf_we_d) begin
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q       <= PRI_ALU;
      ld_older_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rr_q       <= rr_d;
      ld_older_q <= ld_older_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign wb_busy  = alu_hold_v || ld_hold_v;

`ifdef WB_BYPASS_EN
  logic alu_match, ld_match, infl_match;

  // Youngest pending value wins, then the write landing at the next edge.
  always_comb begin
    alu_match  = alu_hold_v && (alu_hold_addr == fwd_raddr);
    ld_match   = ld_hold_v && (ld_hold_addr == fwd_raddr);
    infl_match = rf_we_q && (rf_waddr_q == fwd_raddr);
    fwd_hit    = 1'b0;
    fwd_data   = '0;
    if (fwd_raddr != ADDR_W'(ZERO_REG)) begin
      if (alu_match && ld_match) begin
        fwd_hit  = 1'b1;
        fwd_data = ld_older_q ? alu_hold_data : ld_hold_data;
      end else if (alu_match) begin
        fwd_hit  = 1'b1;
        fwd_data = alu_hold_data;
      end else if (ld_match) begin
        fwd_hit  = 1'b1;
        fwd_data = ld_hold_data;
      end else if (infl_match) begin
        fwd_hit  = 1'b1;
        fwd_data = rf_wdata_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized scoreboard bench for wb_write_arbiter: a timestamp-based reference
// model predicts readiness, occupancy and the ordered stream of register writes.
module tb_wb_write_arbiter;
  import wb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_valid, ld_valid;
  logic [2:0] alu_addr, ld_addr;
  logic [7:0] alu_data, ld_data;
  logic       alu_ready, ld_ready;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       wb_busy;
`ifdef WB_BYPASS_EN
  logic [2:0] fwd_raddr;
  logic       fwd_hit;
  logic [7:0] fwd_data;
`endif

  always #5 clk = ~clk;

  wb_write_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_valid(alu_valid),
    .alu_addr (alu_addr),
    .alu_data (alu_data),
    .alu_ready(alu_ready),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .wb_busy  (wb_busy)
`ifdef WB_BYPASS_EN
    ,
    .fwd_raddr(fwd_raddr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: pending requests with capture times, a round-robin flag
  // and the expected write stream.
  bit         m_alu_v, m_ld_v;
  logic [2:0] m_alu_a, m_ld_a;
  logic [7:0] m_alu_d, m_ld_d;
  int         m_alu_t, m_ld_t;
  bit         m_rr_ld;
  bit         m_last_v;
  wb_entry_t  m_last;
  int         cyc = 0;
  wb_entry_t  exp_q[$];
  logic [7:0] m_rf[8]   = '{default: 8'h00};
  logic [7:0] shadow[8] = '{default: 8'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: called at posedge+1, returns at the following posedge+1.
  task automatic drive_cycle(input bit av, input logic [2:0] aa, input logic [7:0] ad,
                             input bit lv, input logic [2:0] la, input logic [7:0] ldd,
                             input bit rst);
    bit        ag, lg, rr_flip, exp_ar, exp_lr, pushed;
    wb_entry_t e;
`ifdef WB_BYPASS_EN
    logic [2:0] ra;
    bit         am, lm, eh;
    logic [7:0] ed;
    ra = 3'($urandom_range(0, 7));
    fwd_raddr = ra;
    am = m_alu_v && (m_alu_a == ra);
    lm = m_ld_v && (m_ld_a == ra);
    eh = 1'b0;
    ed = 8'h00;
    if (ra != 3'd0) begin
      if (am && lm) begin
        eh = 1'b1;
        ed = (m_ld_t <= m_alu_t) ? m_alu_d : m_ld_d;
      end else if (am) begin
        eh = 1'b1;
        ed = m_alu_d;
      end else if (lm) begin
        eh = 1'b1;
        ed = m_ld_d;
      end else if (m_last_v && m_last.addr == ra) begin
        eh = 1'b1;
        ed = m_last.data;
      end
    end
`endif
    alu_valid = av;
    alu_addr  = aa;
    alu_data  = ad;
    ld_valid  = lv;
    ld_addr   = la;
    ld_data   = ldd;
    reset     = rst;

    ag = 1'b0;
    lg = 1'b0;
    rr_flip = 1'b0;
    if (m_alu_v && m_ld_v) begin
      if (m_alu_a == m_ld_a) begin
        lg = (m_ld_t <= m_alu_t);
        ag = !lg;
      end else begin
        lg = m_rr_ld;
        ag = !m_rr_ld;
        rr_flip = 1'b1;
      end
    end else begin
      ag = m_alu_v;
      lg = m_ld_v;
    end
    exp_ar = !rst && (!m_alu_v || ag);
    exp_lr = !rst && (!m_ld_v || lg);

    #1;
    check("alu_ready", alu_ready, exp_ar);
    check("ld_ready", ld_ready, exp_lr);
`ifdef WB_BYPASS_EN
    check("fwd_hit", fwd_hit, eh);
    check("fwd_data", fwd_data, ed);
`endif

    pushed = 1'b0;
    e = '0;
    if (rst) begin
      m_alu_v = 1'b0;
      m_ld_v  = 1'b0;
      m_rr_ld = 1'b0;
    end else begin
      if (rr_flip) m_rr_ld = !m_rr_ld;
      if (ag && m_alu_a != 3'd0) begin
        e = '{valid: 1'b1, addr: m_alu_a, data: m_alu_d};
        pushed = 1'b1;
      end
      if (lg && m_ld_a != 3'd0) begin
        e = '{valid: 1'b1, addr: m_ld_a, data: m_ld_d};
        pushed = 1'b1;
      end
      if (pushed) begin
        exp_q.push_back(e);
        m_rf[e.addr] = e.data;
      end
      if (ag) m_alu_v = 1'b0;
      if (lg) m_ld_v = 1'b0;
      if (av && exp_ar) begin
        m_alu_v = 1'b1; m_alu_a = aa; m_alu_d = ad; m_alu_t = cyc;
      end
      if (lv && exp_lr) begin
        m_ld_v = 1'b1; m_ld_a = la; m_ld_d = ldd; m_ld_t = cyc;
      end
    end
    m_last_v = pushed;
    m_last   = e;

    @(posedge clk);
    cyc++;
    #1;
    check("wb_busy", wb_busy, m_alu_v || m_ld_v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  // Monitor: every written value must be the next expected write, on time.
  initial begin
    wb_entry_t got;
    forever begin
      @(posedge clk);
      #1;
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got r%0d=0x%0h, expected no write (cycle %0d)",
                   rf_waddr, rf_wdata, cyc);
        end else begin
          got = exp_q.pop_front();
          check("rf_waddr", rf_waddr, got.addr);
          check("rf_wdata", rf_wdata, got.data);
        end
        shadow[rf_waddr] = rf_wdata;
      end else if (exp_q.size() != 0) begin
        got = exp_q.pop_front();
        check("rf_we", rf_we, 1'b1);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_addr  = '0; ld_data  = '0;
`ifdef WB_BYPASS_EN
    fwd_raddr = '0;
`endif
    @(posedge clk);
    #1;
    drive_cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1);
    drive_cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1);
    check("reset_rf_we", rf_we, 1'b0);
    check("reset_rf_waddr", rf_waddr, 3'd0);
    check("reset_rf_wdata", rf_wdata, 8'h00);

    // Single ALU write.
    drive_cycle(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b0);
    idle(3);
    check("alu_only_r3", shadow[3], 8'h5A);

    // Contention on different addresses with fresh data every cycle.
    for (int i = 0; i < 6; i++)
      drive_cycle(1'b1, 3'd1, 8'(8'h11 + i), 1'b1, 3'd2, 8'(8'h22 + i), 1'b0);
    idle(4);

    // Same-cycle capture to the same register: load first, ALU last.
    drive_cycle(1'b1, 3'd4, 8'hBB, 1'b1, 3'd4, 8'hAA, 1'b0);
    idle(4);
    check("waw_r4", shadow[4], 8'hBB);

    // Write to the zero register is dropped.
    drive_cycle(1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b0);
    idle(3);
    check("zero_reg", shadow[0], 8'h00);

    // Both entries full, then reset for one cycle.
    drive_cycle(1'b1, 3'd6, 8'h66, 1'b1, 3'd5, 8'h33, 1'b0);
    drive_cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1);
    check("midreset_rf_we", rf_we, 1'b0);
    idle(4);

    // Randomized traffic on a narrow address range to provoke collisions.
    for (int i = 0; i < 1500; i++)
      drive_cycle($urandom_range(0, 99) < 70, 3'($urandom_range(0, 3)), 8'($urandom),
                  $urandom_range(0, 99) < 70, 3'($urandom_range(0, 3)), 8'($urandom),
                  $urandom_range(0, 99) == 0);
    idle(6);

    check("drain", exp_q.size(), 0);
    for (int r = 1; r < 8; r++) check($sformatf("final_r%0d", r), shadow[r], m_rf[r]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
